cell_hist_accum: RTL and testbench

- Builds one 9-bin HOG cell histogram per cell from a raster pixel stream of (bin, magnitude) votes.
- Sits upstream of norm_block and drives its cell histogram valid/ready input.
- Holds one partial histogram per cell column across a band of cell rows.
- Emits each cell histogram in raster cell order as soon as the cell's last pixel is accepted.

---
 rtl/cell_hist_accum.sv | 106 ++++++++++
 tb/tb_cell_hist_accum.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_hist_accum.sv
// Accumulates raster (bin, magnitude) votes into one 9-bin histogram per HOG cell,
// keeping a partial histogram per cell column and emitting each finished cell in raster order.
module cell_hist_accum #(
  parameter int IMAGE_WIDTH        = 64,
  parameter int IMAGE_HEIGHT       = 480,
  parameter int CELL_ROW_PIXELS    = 8,
  parameter int CELL_COLUMN_PIXELS = 8,
  parameter int BIN_WIDTH          = 14,
  parameter int BINS               = 9,
  parameter int MAG_WIDTH          = 8,
  parameter int HISTOGRAM_WIDTH    = BIN_WIDTH*(BINS+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 bin_index,
  input  logic [MAG_WIDTH-1:0]       magnitude,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HISTOGRAM_WIDTH-1:0] cell_histogram,
  output logic                       out_last
);

  localparam int NUM_CX = IMAGE_WIDTH / CELL_ROW_PIXELS;
  localparam int XW     = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  // Slot BINS holds the running sum of every accepted magnitude.
  typedef logic [BINS:0][BIN_WIDTH-1:0] hist_t;

  hist_t         partial [NUM_CX];
  hist_t         cur;
  hist_t         updated;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] cx;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          complete;
  logic          frame_end;
  logic          bin_ok;

  function automatic logic [BIN_WIDTH-1:0] sat_add(input logic [BIN_WIDTH-1:0] a,
                                                   input logic [MAG_WIDTH-1:0] m);
    logic [BIN_WIDTH:0] s;
    s = {1'b0, a} + (BIN_WIDTH+1)'(m);
    return s[BIN_WIDTH] ? '1 : s[BIN_WIDTH-1:0];
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign cx        = x / XW'(CELL_ROW_PIXELS);
  assign col_end   = (x % XW'(CELL_ROW_PIXELS)) == XW'(CELL_ROW_PIXELS - 1);
  assign row_end   = (y % YW'(CELL_COLUMN_PIXELS)) == YW'(CELL_COLUMN_PIXELS - 1);
  assign complete  = accept && col_end && row_end;
  assign frame_end = (x == X_LAST) && (y == Y_LAST);
  assign bin_ok    = bin_index < 4'(BINS);

  // Partial histogram of the current column with this vote folded in.
  always_comb begin
    cur = '0;
    for (int c = 0; c < NUM_CX; c++) begin
      if (cx == XW'(c)) cur = partial[c];
    end
    updated = cur;
    if (bin_ok) begin
      updated[bin_index] = sat_add(cur[bin_index], magnitude);
      updated[BINS]      = sat_add(cur[BINS], magnitude);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x              <= '0;
      y              <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      cell_histogram <= '0;
      for (int c = 0; c < NUM_CX; c++) partial[c] <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        for (int c = 0; c < NUM_CX; c++) begin
          if (cx == XW'(c)) partial[c] <= complete ? '0 : updated;
        end
      end
      // A completion can only be accepted when the output register is free or draining.
      if (complete) begin
        cell_histogram <= updated;
        out_valid      <= 1'b1;
        out_last       <= frame_end;
      end
    end
  end

endmodule

// File: tb/tb_cell_hist_accum.sv
// Randomised self-checking bench for cell_hist_accum against a whole-frame cell model.
module tb_cell_hist_accum;

  localparam int W    = 64;
  localparam int H    = 16;
  localparam int BW   = 14;
  localparam int HW   = BW*10;
  localparam int NCX  = 8;
  localparam int CPF  = 16;
  localparam int MAXV = 16383;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    bin_index = '0;
  logic [7:0]    magnitude = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [HW-1:0] cell_histogram;
  logic          out_last;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ready_mode = 0;
  logic ready_val = 1'b1;
  logic stall_timeout = 1'b0;
  logic drain_timeout = 1'b0;
  logic prev_ov = 1'b0;
  logic prev_xfer = 1'b0;

  int            vote_bin[$];
  int            vote_mag[$];
  int            vote_edge[$];
  int            present_edge[$];
  logic [HW-1:0] got_hist[$];
  logic          got_last[$];
  logic [HW-1:0] exp_hist[$];
  logic          exp_last[$];

  cell_hist_accum #(.IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_index(bin_index), .magnitude(magnitude), .out_valid(out_valid),
    .out_ready(out_ready), .cell_histogram(cell_histogram), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Observer: logs accepted votes, presented histograms and transferred histograms.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (out_valid && (!prev_ov || prev_xfer)) present_edge.push_back(cyc);
      if (out_valid && out_ready) begin
        got_hist.push_back(cell_histogram);
        got_last.push_back(out_last);
      end
      if (in_valid && in_ready) begin
        vote_bin.push_back(int'(bin_index));
        vote_mag.push_back(int'(magnitude));
        vote_edge.push_back(cyc);
      end
      prev_ov   = out_valid;
      prev_xfer = out_valid && out_ready;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vote_bin.delete(); vote_mag.delete(); vote_edge.delete();
    present_edge.delete(); got_hist.delete(); got_last.delete();
    stall_timeout = 1'b0;
    drain_timeout = 1'b0;
  endtask

  // mode 0: fixed vote; mode 1: every 4th vote uses bin 11; mode 2: random bin 0..15 and magnitude.
  task automatic send_votes(input int n, input int mode, input int fbin, input int fmag, input int gaps);
    for (int i = 0; i < n; i++) begin
      int b;
      int m;
      int waited;
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      b = fbin;
      m = fmag;
      if (mode == 1 && i % 4 == 3) b = 11;
      if (mode == 2) begin
        b = $urandom_range(0, 15);
        m = $urandom_range(0, 255);
      end
      in_valid  = 1'b1;
      bin_index = 4'(b);
      magnitude = 8'(m);
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        stall_timeout = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    repeat (4) @(negedge clk);
    while (out_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (out_valid) drain_timeout = 1'b1;
  endtask

  // Reference: every vote is assigned to its frame cell by pixel position; a cell is
  // emitted when its bottom-right pixel arrives, last flag on the frame's final pixel.
  task automatic build_expected();
    int acc [128][10];
    exp_hist.delete();
    exp_last.delete();
    for (int c = 0; c < 128; c++)
      for (int b = 0; b < 10; b++) acc[c][b] = 0;
    for (int v = 0; v < vote_bin.size(); v++) begin
      int px;
      int py;
      int id;
      px = v % W;
      py = (v / W) % H;
      id = ((v / (W*H)) * CPF + (py / 8) * NCX + px / 8) % 128;
      if (vote_bin[v] < 9) begin
        acc[id][vote_bin[v]] += vote_mag[v];
        acc[id][9]           += vote_mag[v];
      end
      if (px % 8 == 7 && py % 8 == 7) begin
        logic [HW-1:0] h;
        h = '0;
        for (int b = 0; b < 10; b++) h[b*BW +: BW] = BW'((acc[id][b] > MAXV) ? MAXV : acc[id][b]);
        exp_hist.push_back(h);
        exp_last.push_back(px == W-1 && py == H-1);
      end
    end
  endtask

  task automatic test_reset();
    ready_mode = 0; ready_val = 1'b1;
    do_reset();
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++; if (out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
    compared++; if (cell_histogram !== '0) begin mismatched++; $display("[TB] FAIL reset_histogram: got %h expected 0", cell_histogram); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_uniform();
    ready_mode = 0; ready_val = 1'b1;
    do_reset();
    send_votes(W*H, 0, 2, 1, 0);
    drain();
    build_expected();
    compared++; if (stall_timeout || drain_timeout) begin mismatched++; $display("[TB] FAIL uniform_timeout: stall %b drain %b expected 0 0", stall_timeout, drain_timeout); end
    compared++; if (got_hist.size() != 16) begin mismatched++; $display("[TB] FAIL uniform_count: got %0d expected 16", got_hist.size()); end
    compared++;
    if (present_edge.size() < 1 || vote_edge.size() < 456 || present_edge[0] != vote_edge[455] + 1) begin
      mismatched++;
      $display("[TB] FAIL uniform_latency: got cycle %0d expected %0d", (present_edge.size() > 0) ? present_edge[0] : -1, (vote_edge.size() > 455) ? vote_edge[455] + 1 : -1);
    end
    for (int k = 0; k < got_hist.size() && k < exp_hist.size(); k++) begin
      logic [HW-1:0] want;
      want = '0;
      want[2*BW +: BW] = BW'(64);
      want[9*BW +: BW] = BW'(64);
      compared++; if (got_hist[k] !== want) begin mismatched++; $display("[TB] FAIL uniform_hist[%0d]: got %h expected %h", k, got_hist[k], want); end
      compared++; if (got_last[k] !== exp_last[k]) begin mismatched++; $display("[TB] FAIL uniform_last[%0d]: got %b expected %b", k, got_last[k], exp_last[k]); end
    end
  endtask

  task automatic test_max_magnitude();
    ready_mode = 0; ready_val = 1'b1;
    do_reset();
    send_votes(W*H, 0, 8, 255, 0);
    drain();
    build_expected();
    compared++; if (got_hist.size() != exp_hist.size() || got_hist.size() != 16) begin mismatched++; $display("[TB] FAIL maxmag_count: got %0d expected 16", got_hist.size()); end
    for (int k = 0; k < got_hist.size() && k < exp_hist.size(); k++) begin
      compared++;
      if (got_hist[k][8*BW +: BW] !== BW'(16320) || got_hist[k][9*BW +: BW] !== BW'(16320) || got_hist[k] !== exp_hist[k]) begin
        mismatched++;
        $display("[TB] FAIL maxmag_hist[%0d]: got %h expected %h", k, got_hist[k], exp_hist[k]);
      end
    end
  endtask

  task automatic test_invalid_bins();
    ready_mode = 0; ready_val = 1'b1;
    do_reset();
    send_votes(W*H, 1, 0, 3, 0);
    drain();
    build_expected();
    compared++; if (vote_bin.size() != W*H) begin mismatched++; $display("[TB] FAIL invbin_votes: got %0d expected %0d", vote_bin.size(), W*H); end
    compared++; if (got_hist.size() != 16) begin mismatched++; $display("[TB] FAIL invbin_count: got %0d expected 16", got_hist.size()); end
    for (int k = 0; k < got_hist.size() && k < exp_hist.size(); k++) begin
      compared++;
      if (got_hist[k][0 +: BW] !== BW'(144) || got_hist[k][9*BW +: BW] !== BW'(144) || got_hist[k] !== exp_hist[k]) begin
        mismatched++;
        $display("[TB] FAIL invbin_hist[%0d]: got %h expected %h", k, got_hist[k], exp_hist[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 0; ready_val = 1'b0;
    do_reset();
    fork
      send_votes(W*H, 0, 5, 2, 0);
      begin
        int k;
        logic [HW-1:0] held;
        logic held_last;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 2000) begin
          @(negedge clk);
          k++;
        end
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_first_valid: got %b expected 1", out_valid); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready_drop: got %b expected 0", in_ready); end
        held = cell_histogram;
        held_last = out_last;
        repeat (20) begin
          @(negedge clk);
          compared++;
          if (cell_histogram !== held || out_last !== held_last || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got hist %h valid %b ready %b expected hist %h valid 1 ready 0", cell_histogram, out_valid, in_ready, held);
          end
        end
        ready_val = 1'b1;
      end
    join
    drain();
    build_expected();
    compared++; if (stall_timeout || drain_timeout) begin mismatched++; $display("[TB] FAIL bp_timeout: stall %b drain %b expected 0 0", stall_timeout, drain_timeout); end
    compared++; if (vote_bin.size() != W*H) begin mismatched++; $display("[TB] FAIL bp_vote_count: got %0d expected %0d", vote_bin.size(), W*H); end
    compared++; if (got_hist.size() != 16) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected 16", got_hist.size()); end
    compared++;
    if (got_hist.size() < 2 || got_hist[1][5*BW +: BW] !== BW'(128) || got_hist[1][9*BW +: BW] !== BW'(128)) begin
      mismatched++;
      $display("[TB] FAIL bp_second_cell: got %h expected bin5=128 sum=128", (got_hist.size() > 1) ? got_hist[1] : '0);
    end
    for (int k = 0; k < got_hist.size() && k < exp_hist.size(); k++) begin
      compared++; if (got_hist[k] !== exp_hist[k]) begin mismatched++; $display("[TB] FAIL bp_hist[%0d]: got %h expected %h", k, got_hist[k], exp_hist[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    ready_mode = 0; ready_val = 1'b1;
    do_reset();
    send_votes(5*W + 30, 0, 3, 4, 0);
    do_reset();
    send_votes(460, 0, 4, 1, 0);
    drain();
    compared++;
    if (present_edge.size() < 1 || vote_edge.size() < 456 || present_edge[0] != vote_edge[455] + 1) begin
      mismatched++;
      $display("[TB] FAIL midrst_latency: got cycle %0d expected %0d", (present_edge.size() > 0) ? present_edge[0] : -1, (vote_edge.size() > 455) ? vote_edge[455] + 1 : -1);
    end
    compared++;
    if (got_hist.size() < 1 || got_hist[0][9*BW +: BW] !== BW'(64) || got_hist[0][4*BW +: BW] !== BW'(64) || got_hist[0][3*BW +: BW] !== BW'(0)) begin
      mismatched++;
      $display("[TB] FAIL midrst_first_hist: got %h expected bin4=64 sum=64 bin3=0", (got_hist.size() > 0) ? got_hist[0] : '0);
    end
  endtask

  task automatic test_back_to_back();
    ready_mode = 1;
    do_reset();
    send_votes(2*W*H, 2, 0, 0, 1);
    ready_mode = 0; ready_val = 1'b1;
    drain();
    build_expected();
    compared++; if (stall_timeout || drain_timeout) begin mismatched++; $display("[TB] FAIL b2b_timeout: stall %b drain %b expected 0 0", stall_timeout, drain_timeout); end
    compared++; if (got_hist.size() != 32) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 32", got_hist.size()); end
    for (int k = 0; k < got_hist.size() && k < exp_hist.size(); k++) begin
      compared++; if (got_hist[k] !== exp_hist[k]) begin mismatched++; $display("[TB] FAIL b2b_hist[%0d]: got %h expected %h", k, got_hist[k], exp_hist[k]); end
      compared++; if (got_last[k] !== (k % 16 == 15)) begin mismatched++; $display("[TB] FAIL b2b_last[%0d]: got %b expected %b", k, got_last[k], (k % 16 == 15)); end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_max_magnitude();
    test_invalid_bins();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
